a429_rx_deframer: RTL

// ARINC429 receive front end. It samples the bipolar RZ line pair RxA/RxB and

---
 rtl/a429_rx_deframer_pkg.sv | 32 +++
 rtl/a429_rx_deframer_if.sv | 37 +++
 rtl/a429_rx_filter.sv | 72 +++++++
 rtl/a429_rx_deframer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/a429_rx_deframer_pkg.sv
// ----------------------------------------------------------------------------
// a429_rx_deframer_pkg
// Shared definitions for the ARINC429 receive path: FSM state encoding,
// line level codes ({A,B}), timer width and the bit-time helper that turns
// a clock frequency and a bit rate into clock cycles per bit.
// ----------------------------------------------------------------------------
package a429_rx_deframer_pkg;

    localparam int TIMER_W = 13;
    localparam int WORD_W  = 32;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_BIT_ON  = 3'd2,
        ST_BIT_OFF = 3'd3,
        ST_DONE    = 3'd4
    } a429_state_e;

    // Encoded as {A,B} so the synchronised pin pair maps directly onto it.
    typedef enum logic [1:0] {
        LVL_NULL = 2'b00,
        LVL_LO   = 2'b01,
        LVL_HI   = 2'b10,
        LVL_ILL  = 2'b11
    } a429_level_e;

    function automatic int bit_time(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage

// File: rtl/a429_rx_deframer_if.sv
// ----------------------------------------------------------------------------
// a429_rx_deframer_if
// Groups the ARINC line pins, rate select and the received-word outputs.
//   RxA, RxB, rec_rate_sel : line side -> deframer
//   rx_word, rx_dat24      : last good word and its 24-bit payload
//   rx_valid, rx_par_err   : new-word pulse and parity flag of that word
//   rx_frm_err, rx_busy    : frame-abort pulse, word-in-progress level
//   state_dbg              : current receive FSM state
// Handshake: rx_valid is a one-cycle pulse with no backpressure; rx_word,
// rx_dat24 and rx_par_err are stable from that cycle until the next pulse,
// so a consumer may sample them on the pulse or at any time afterwards.
// ----------------------------------------------------------------------------
interface a429_rx_deframer_if;
    import a429_rx_deframer_pkg::*;

    logic        RxA;
    logic        RxB;
    logic        rec_rate_sel;
    logic [31:0] rx_word;
    logic [23:0] rx_dat24;
    logic        rx_valid;
    logic        rx_par_err;
    logic        rx_frm_err;
    logic        rx_busy;
    a429_state_e state_dbg;

    modport master (
        output RxA, RxB, rec_rate_sel,
        input  rx_word, rx_dat24, rx_valid, rx_par_err, rx_frm_err, rx_busy, state_dbg
    );

    modport slave (
        input  RxA, RxB, rec_rate_sel,
        output rx_word, rx_dat24, rx_valid, rx_par_err, rx_frm_err, rx_busy, state_dbg
    );

endinterface

// File: rtl/a429_rx_filter.sv
// ----------------------------------------------------------------------------
// a429_rx_filter
// Two-flop synchroniser on the line pair followed by a glitch filter: the
// filtered level only moves to a new code once that code has been sampled
// GLITCH_CLKS times in a row.
//   clk, rst   : system clock, synchronous active-high reset
//   rx_a, rx_b : asynchronous ARINC line pins
//   level      : filtered line level
//   level_chg  : one-cycle strobe, high on the cycle level takes a new value
// ----------------------------------------------------------------------------
module a429_rx_filter
    import a429_rx_deframer_pkg::*;
#(
    parameter int GLITCH_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_a,
    input  logic        rx_b,
    output a429_level_e level,
    output logic        level_chg
);

    localparam int               CNT_W   = $clog2(GLITCH_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_CLKS);

    logic [1:0]       meta_q, sync_q;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    a429_level_e      level_q, level_d;
    logic             chg_q, chg_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        chg_d   = 1'b0;
        // cand/cnt track the run length of the current synchronised code.
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_d == CNT_MAX) && (a429_level_e'(cand_d) != level_q)) begin
            level_d = a429_level_e'(cand_d);
            chg_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            cand_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= LVL_NULL;
            chg_q   <= 1'b0;
        end else begin
            meta_q  <= {rx_a, rx_b};
            sync_q  <= meta_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            chg_q   <= chg_d;
        end
    end

    assign level     = level_q;
    assign level_chg = chg_q;

endmodule

// File: rtl/a429_rx_deframer.sv
// ----------------------------------------------------------------------------
// a429_rx_deframer
// ARINC429 receive front end: conditions the bipolar RZ line, times each bit,
// shifts 32 bits LSB first and delivers the word with an odd-parity flag.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of a429_rx_deframer_if (line pins, rate select,
//              received word/payload, valid/parity/frame-error/busy, state)
// ----------------------------------------------------------------------------
module a429_rx_deframer
    import a429_rx_deframer_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int HI_BPS      = 100_000,
    parameter int LO_BPS      = 12_500,
    parameter int GLITCH_CLKS = 8,
    parameter int GAP_BITS    = 2
) (
    input logic               clk,
    input logic               rst,
    a429_rx_deframer_if.slave bus
);

    localparam int T_HI = bit_time(CLK_HZ, HI_BPS);
    localparam int T_LO = bit_time(CLK_HZ, LO_BPS);

    localparam logic [TIMER_W-1:0] HI_T   = TIMER_W'(T_HI);
    localparam logic [TIMER_W-1:0] HI_T34 = TIMER_W'((T_HI * 3) / 4);
    localparam logic [TIMER_W-1:0] HI_T32 = TIMER_W'((T_HI * 3) / 2);
    localparam logic [TIMER_W-1:0] HI_GAP = TIMER_W'(T_HI * GAP_BITS);
    localparam logic [TIMER_W-1:0] LO_T   = TIMER_W'(T_LO);
    localparam logic [TIMER_W-1:0] LO_T34 = TIMER_W'((T_LO * 3) / 4);
    localparam logic [TIMER_W-1:0] LO_T32 = TIMER_W'((T_LO * 3) / 2);
    localparam logic [TIMER_W-1:0] LO_GAP = TIMER_W'(T_LO * GAP_BITS);

    a429_level_e        level;
    logic               level_chg;
    a429_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [31:0]        shift_q, shift_d;
    logic [31:0]        word_q, word_d;
    logic               valid_q, valid_d;
    logic               par_q, par_d;
    logic               frm_q, frm_d;
    logic               rate_q;

    logic [TIMER_W-1:0] t_bit, t_34, t_32, t_gap;
    logic               rate_chg, new_bit, abort;

    a429_rx_filter #(.GLITCH_CLKS(GLITCH_CLKS)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .rx_a      (bus.RxA),
        .rx_b      (bus.RxB),
        .level     (level),
        .level_chg (level_chg)
    );

    assign t_bit    = bus.rec_rate_sel ? HI_T   : LO_T;
    assign t_34     = bus.rec_rate_sel ? HI_T34 : LO_T34;
    assign t_32     = bus.rec_rate_sel ? HI_T32 : LO_T32;
    assign t_gap    = bus.rec_rate_sel ? HI_GAP : LO_GAP;
    assign rate_chg = (rate_q != bus.rec_rate_sel);
    assign new_bit  = level_chg && ((level == LVL_HI) || (level == LVL_LO));

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        par_d     = par_q;
        frm_d     = 1'b0;
        abort     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (level != LVL_NULL) begin
                    timer_d = '0;
                end else if (timer_q >= t_gap) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (level == LVL_ILL) begin
                    abort = 1'b1;
                end else if (new_bit) begin
                    shift_d   = {level == LVL_HI, shift_q[31:1]};
                    bit_cnt_d = 6'd1;
                    timer_d   = '0;
                    state_d   = ST_BIT_ON;
                end
            end
            ST_BIT_ON: begin
                if (level == LVL_ILL) begin
                    abort = 1'b1;
                end else if (level == LVL_NULL) begin
                    state_d = ST_BIT_OFF;
                end else if (timer_q >= t_bit) begin
                    abort = 1'b1;
                end
            end
            ST_BIT_OFF: begin
                if (level == LVL_ILL) begin
                    abort = 1'b1;
                end else if (new_bit) begin
                    // Early edge means rate mismatch; a 33rd bit means no gap.
                    if ((timer_q < t_34) || (bit_cnt_q == 6'd32)) begin
                        abort = 1'b1;
                    end else begin
                        shift_d   = {level == LVL_HI, shift_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        timer_d   = '0;
                        state_d   = ST_BIT_ON;
                    end
                end else if (bit_cnt_q == 6'd32) begin
                    if (timer_q >= t_bit) begin
                        state_d = ST_DONE;
                    end
                end else if (timer_q > t_32) begin
                    abort = 1'b1;
                end
            end
            ST_DONE: begin
                word_d    = shift_q;
                valid_d   = 1'b1;
                par_d     = ~^shift_q;
                bit_cnt_d = '0;
                timer_d   = '0;
                state_d   = ST_SYNC;
            end
            default: begin
                state_d = ST_SYNC;
                timer_d = '0;
            end
        endcase

        if (abort) begin
            frm_d     = 1'b1;
            bit_cnt_d = '0;
            timer_d   = '0;
            state_d   = ST_SYNC;
        end

        // A rate switch silently drops whatever is in flight.
        if (rate_chg) begin
            frm_d     = 1'b0;
            valid_d   = 1'b0;
            word_d    = word_q;
            par_d     = par_q;
            bit_cnt_d = '0;
            timer_d   = '0;
            state_d   = ST_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SYNC;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            par_q     <= 1'b0;
            frm_q     <= 1'b0;
            rate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            par_q     <= par_d;
            frm_q     <= frm_d;
            rate_q    <= bus.rec_rate_sel;
        end
    end

    assign bus.rx_word    = word_q;
    assign bus.rx_dat24   = word_q[31:8];
    assign bus.rx_valid   = valid_q;
    assign bus.rx_par_err = par_q;
    assign bus.rx_frm_err = frm_q;
    assign bus.rx_busy    = (state_q == ST_BIT_ON) || (state_q == ST_BIT_OFF);
    assign bus.state_dbg  = state_q;

endmodule
